// File: rtl/sr_latch_controller_if.sv
// Request handshake bundle for sr_latch_controller: per-requester valid/target
// from the requesters (master) and the one-hot grant back from the controller (slave).
interface sr_latch_controller_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_set;
  logic [NUM_REQ-1:0] req_ready;

  modport master (output req_valid, output req_set, input req_ready);
  modport slave  (input req_valid, input req_set, output req_ready);
endinterface

// File: rtl/sr_latch_controller.sv
// Round-robin sequencer sharing one SR latch: drives a registered s/r pulse, a settle gap
// and, with LIBSV_SR_LATCH_CTRL_CHECK_EN defined, a readback check of q/q_n.
module sr_latch_controller #(
  parameter int  NUM_REQ      = 2,
  parameter int  PULSE_CYCLES = 2,
  parameter int  GAP_CYCLES   = 1,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sr_latch_controller_if.slave   req,
  output logic                   s,
  output logic                   r,
  input  logic                   q,
  input  logic                   q_n,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
    ,CHECK = 2'd3
`endif
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [ID_W-1:0]    grant_d;
  logic               target, target_d;
  logic               s_d, r_d, done_d, err_d;
  logic               mismatch;

  // Arbitration: lowest valid index at or above ptr, otherwise lowest valid overall.
  logic [NUM_REQ-1:0] ptr_mask, upper, pick_vec;
  logic [ID_W-1:0]    win;
  logic               found;

  always_comb begin
    ptr_mask = '0;
    win      = '0;
    for (int i = 0; i < NUM_REQ; i++) ptr_mask[i] = (i >= int'(ptr));
    upper    = req.req_valid & ptr_mask;
    pick_vec = (|upper) ? upper : req.req_valid;
    found    = |req.req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) win = ID_W'(i);
    end
  end

  assign req.req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
  assign busy          = (state != IDLE);

`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
  assign mismatch = (q != target) | (q_n != ~target);
`else
  // Readback is not used in this build.
  logic unused_readback;
  assign unused_readback = q ^ q_n;
  assign mismatch        = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ptr_d    = ptr;
    grant_d  = grant_id;
    target_d = target;
    s_d      = 1'b0;
    r_d      = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          target_d = |(req.req_set & req.req_ready);
          grant_d  = win;
          ptr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          s_d      = target_d;
          r_d      = ~target_d;
          cnt_d    = CNT_W'(PULSE_CYCLES - 1);
          state_d  = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          if (GAP_CYCLES != 0) begin
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
            state_d = CHECK;
`else
            done_d  = 1'b1;
            state_d = IDLE;
`endif
          end
        end else begin
          cnt_d = cnt - 1'b1;
          s_d   = s;
          r_d   = r;
        end
      end
      GAP: begin
        if (cnt == '0) begin
`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
          state_d = CHECK;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
      CHECK: begin
        done_d  = 1'b1;
        err_d   = mismatch;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant_id <= '0;
      target   <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      grant_id <= grant_d;
      target   <= target_d;
      s        <= s_d;
      r        <= r_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_controller.sv
// Directed bench for sr_latch_controller with a clocked SR latch model on s/r;
// expectations follow the configured latency (LIBSV_SR_LATCH_CTRL_CHECK_EN on or off).
module tb_sr_latch_controller;

  localparam int N = 2;
  localparam int P = 2;
  localparam int G = 1;
`ifdef LIBSV_SR_LATCH_CTRL_CHECK_EN
  localparam int LAT = P + G + 2;
  localparam bit CHK = 1'b1;
`else
  localparam int LAT = P + G + 1;
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       s, r, q, q_n, busy, done, err;
  logic [0:0] grant_id;
  logic       lq, latch_init, force_q0;

  int n_cmp = 0;
  int n_bad = 0;

  sr_latch_controller_if #(.NUM_REQ(N)) req_if ();

  sr_latch_controller #(
    .NUM_REQ(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst(rst), .req(req_if),
    .s(s), .r(r), .q(q), .q_n(q_n),
    .busy(busy), .grant_id(grant_id), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Latch model; force_q0 pins the readback to the cleared value.
  always @(posedge clk) begin
    if (latch_init)     lq <= 1'b0;
    else if (s && !r)   lq <= 1'b1;
    else if (r && !s)   lq <= 1'b0;
  end
  assign q   = force_q0 ? 1'b0 : lq;
  assign q_n = force_q0 ? 1'b1 : ~lq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from requester idx; checks every cycle from accept to done.
  task automatic do_req(input int idx, input bit set, input bit exp_err, input bit chk_q,
                        input string tag);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    req_if.req_valid = oh;
    req_if.req_set   = set ? oh : '0;
    #1;
    check({tag, ".ready"}, 32'(req_if.req_ready), 32'(oh));
    tick();
    req_if.req_valid = '0;
    req_if.req_set   = '0;
    check({tag, ".gid"}, 32'(grant_id), idx);
    for (int k = 1; k <= LAT; k++) begin
      check($sformatf("%s.s@%0d", tag, k), s, (k <= P) && set);
      check($sformatf("%s.r@%0d", tag, k), r, (k <= P) && !set);
      check($sformatf("%s.busy@%0d", tag, k), busy, k < LAT);
      check($sformatf("%s.done@%0d", tag, k), done, k == LAT);
      check($sformatf("%s.err@%0d", tag, k), err, (k == LAT) && exp_err);
      if (k < LAT) tick();
    end
    if (chk_q) begin
      check({tag, ".q"}, q, set);
      check({tag, ".q_n"}, q_n, !set);
    end
    tick();
    check({tag, ".done_off"}, done, 1'b0);
    check({tag, ".err_off"}, err, 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    latch_init       = 1'b1;
    force_q0         = 1'b0;
    req_if.req_valid = '0;
    req_if.req_set   = '0;
    repeat (3) tick();
    latch_init = 1'b0;
    rst        = 1'b0;

    // Reset state
    check("rst.s", s, 1'b0);
    check("rst.r", r, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.gid", 32'(grant_id), 0);
    check("rst.ready", 32'(req_if.req_ready), 0);
    check("rst.q", q, 1'b0);

    // Single set, then re-set (still pulsed), then clear from requester 1
    do_req(0, 1'b1, 1'b0, 1'b1, "set0");
    do_req(1, 1'b1, 1'b0, 1'b1, "set1");
    do_req(1, 1'b0, 1'b0, 1'b1, "clr1");

    // Readback pinned low during a set request
    force_q0 = 1'b1;
    do_req(0, 1'b1, CHK, 1'b0, "mism");
    force_q0 = 1'b0;

    // Reset in pulse cycle 1 (ptr is 1 here)
    req_if.req_valid = 2'b01;
    req_if.req_set   = 2'b01;
    #1;
    tick();
    req_if.req_valid = '0;
    req_if.req_set   = '0;
    check("mrst.s_before", s, 1'b1);
    rst = 1'b1;
    tick();
    check("mrst.s", s, 1'b0);
    check("mrst.r", r, 1'b0);
    check("mrst.busy", busy, 1'b0);
    check("mrst.done", done, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      check($sformatf("mrst.nodone@%0d", k), done, 1'b0);
    end

    // Contention with both held: grants alternate from requester 0 (ptr back to 0)
    req_if.req_valid = 2'b11;
    req_if.req_set   = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      int w;
      w = 0;
      while (req_if.req_ready == '0 && w < 20) begin
        tick();
        w++;
      end
      check($sformatf("cont.wait%0d", g), 32'(w < 20), 1);
      check($sformatf("cont.ready%0d", g), 32'(req_if.req_ready), 32'(2'b01 << (g % 2)));
      tick();
      check($sformatf("cont.gid%0d", g), 32'(grant_id), g % 2);
      check($sformatf("cont.busy%0d", g), busy, 1'b1);
      check($sformatf("cont.ready_low%0d", g), 32'(req_if.req_ready), 0);
    end
    req_if.req_valid = '0;
    req_if.req_set   = '0;
    repeat (LAT + 1) tick();
    check("cont.idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sr_latch_controller.md
# sr_latch_controller

Synchronous sequencer that shares one `sr_latch` among `NUM_REQ` requesters. Requesters ask to set or clear the latch through a valid/ready handshake. A round-robin arbiter picks one request at a time. The controller then drives a fixed-width, non-overlapping `s` or `r` pulse into the latch, waits a settle gap, and optionally reads the latch back to verify it.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; must be ≥ 1.
- `PULSE_CYCLES`, default 2: cycles `s`/`r` is held high; must be ≥ 1.
- `GAP_CYCLES`, default 1: settle cycles with `s` = `r` = 0 after the pulse; may be 0.

Ports:
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, `NUM_REQ` bits: per-requester request.
- `req_set` input, `NUM_REQ` bits: per-requester target (1 = set q, 0 = clear q); valid with `req_valid`.
- `req_ready` output, `NUM_REQ` bits: one-hot grant; a request is accepted at the edge where `req_valid[i]` & `req_ready[i]`.
- `s` output, 1 bit: set drive to the latch; registered.
- `r` output, 1 bit: reset drive to the latch; registered.
- `q` input, 1 bit: latch output readback.
- `q_n` input, 1 bit: latch complementary readback.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `grant_id` output, `$clog2(NUM_REQ)` bits (min 1): index of the last accepted requester; held until the next accept.
- `done` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: one-cycle readback-mismatch pulse, coincident with `done`.

## Operation
- States: IDLE → PULSE → GAP → CHECK → IDLE.
  - GAP is skipped when `GAP_CYCLES` = 0.
  - CHECK exists only with `LIBSV_SR_LATCH_CTRL_CHECK_EN`.
- IDLE arbitration:
  - Round-robin pointer `ptr`; the winner is the lowest index ≥ `ptr` with `req_valid` high, wrapping to index 0.
  - `req_ready` is combinational from `req_valid` and `ptr`, and is nonzero only in IDLE.
- On accept:
  - Latch `target` = `req_set[i]` and `grant_id` = i.
  - Set `ptr` = (i+1) mod `NUM_REQ`.
  - Go to PULSE.
- PULSE: `s` = `target`, `r` = ~`target` for exactly `PULSE_CYCLES` cycles, tracked by a down-counter. `s` and `r` are never high together.
- GAP: `s` = `r` = 0 for `GAP_CYCLES` cycles.
- CHECK (one cycle):
  - `s` = `r` = 0.
  - Mismatch = (`q` ≠ `target`) | (`q_n` ≠ ~`target`).
  - At the exit edge, register `done` = 1 and `err` = mismatch.
- Completion without CHECK: the last GAP edge (or the last PULSE edge if `GAP_CYCLES` = 0) registers `done` = 1.
- A request is always pulsed, even if the latch already holds the target.
- Requests not granted in IDLE wait. The controller never drops them and never latches them internally.
- Reset values: `s` = `r` = `busy` = `done` = `err` = 0, `grant_id` = 0, `ptr` = 0, state IDLE.
- Reset mid-operation:
  - The pulse is aborted immediately: `s`/`r` are low the cycle after the reset edge.
  - No `done` is issued for the aborted request.
  - The latch content is left as-is.

## Timing
- Let P = `PULSE_CYCLES`, G = `GAP_CYCLES`, and accept edge = E0.
- Pulse: `s`/`r` high in cycles 1..P after E0.
- Gap: low in cycles P+1..P+G.
- With CHECK:
  - CHECK cycle is P+G+1.
  - `done`/`err` are high in cycle P+G+2, which is already IDLE.
  - A new request can be accepted at the end of that same cycle.
  - Minimum issue interval: P+G+2 cycles.
- Without CHECK: `done` is high in cycle P+G+1; minimum issue interval: P+G+1 cycles.
- `busy` is high in cycles 1 through the last non-IDLE cycle.
- `req_ready` is low whenever `busy` is high.

## Configuration
- `LIBSV_SR_LATCH_CTRL_CHECK_EN` defined:
  - CHECK state is present.
  - `q`/`q_n` are sampled.
  - `err` reports mismatches.
- Undefined:
  - No CHECK state.
  - `q`/`q_n` are ignored (lint-waived).
  - `err` is tied to 0.
  - Latency is one cycle shorter.

## Test plan
Defaults N = 2, P = 2, G = 1, CHECK_EN defined, real `sr_latch` attached.
- Single set: `req_valid` = 01, `req_set` = 01, q initially 0 → `s` high 2 cycles, `r` = 0 throughout, `done` 5 cycles after accept, `err` = 0, q = 1.
- Contention: both valid, `ptr` = 0 → req 0 served first (`grant_id` = 0), req 1 next (`grant_id` = 1); with both held, grants alternate 0, 1, 0, 1.
- Clear after set: set then clear from requester 1 → `r` high 2 cycles, q = 0, `q_n` = 1, `err` = 0; `s` and `r` never simultaneously high.
- Forced mismatch: bench holds q = 0 during a set request → `err` = 1 coincident with `done` = 1, both one cycle.
- Reset mid-PULSE: assert `rst` in pulse cycle 1 → `s` = 0, `busy` = 0, `done` = 0 next cycle; `ptr` back to 0.
- Build without CHECK_EN, set request → `done` 4 cycles after accept, `err` stuck at 0.
